// File: rtl/image_mem_responder.sv
// image_mem_responder
// Memory-side responder for the pixel read/write command interface. Holds a
// DEPTH x DATA_W pixel store and serves one READ or WRITE at a time. Busy
// stays high for a fixed latency. The command then completes with a
// one-cycle done pulse.
//
// Ports
//   clk            system clock, rising edge
//   n_rst          asynchronous reset, active-high
//   instruction    00 NOP, 01 READ, 10 WRITE, 11 reserved (cmd_err)
//   addr_r         read address, sampled on accept
//   addr_w/data_w  write address/data, sampled on accept
//   init_we/addr/data  side-band preload port, usable in any state
//   busy           command in flight, new commands ignored
//   data_r         read data, held until the next read completes
//   read_data_done one-cycle pulse, data_r valid
//   write_done     one-cycle pulse, write committed
//   cmd_err        one-cycle pulse on reserved instruction
//
// state   | meaning
// IDLE    | waiting for a command, busy low
// RD_WAIT | read accepted, counting down RD_LAT
// WR_WAIT | write accepted, counting down WR_LAT

module image_mem_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [1:0]        instruction,
    input  logic [ADDR_W-1:0] addr_r,
    input  logic [ADDR_W-1:0] addr_w,
    input  logic [DATA_W-1:0] data_w,
    input  logic              init_we,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data,
    output logic              busy,
    output logic [DATA_W-1:0] data_r,
    output logic              read_data_done,
    output logic              write_done,
    output logic              cmd_err
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [3:0] RD_CNT0 = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_CNT0 = 4'(WR_LAT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_rd_accept;
    logic w_wr_accept;
    logic w_rd_commit;
    logic w_wr_commit;
    logic w_cmd_err_nxt;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rd_accept   = 1'b0;
        w_wr_accept   = 1'b0;
        w_rd_commit   = 1'b0;
        w_wr_commit   = 1'b0;
        w_cmd_err_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                case (instruction)
                    2'b01: begin
                        w_rd_accept = 1'b1;
                        w_cnt_nxt   = RD_CNT0;
                        w_state_nxt = RD_WAIT;
                    end
                    2'b10: begin
                        w_wr_accept = 1'b1;
                        w_cnt_nxt   = WR_CNT0;
                        w_state_nxt = WR_WAIT;
                    end
                    2'b11:   w_cmd_err_nxt = 1'b1;
                    default: ;
                endcase
            end
            RD_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_rd_commit = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            WR_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_wr_commit = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Busy drops in the done cycle so a new command can be taken at the
    // very next edge.
    assign busy = (r_state != IDLE);

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            r_state        <= IDLE;
            r_cnt          <= 4'd0;
            r_rd_addr      <= '0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            data_r         <= '0;
            read_data_done <= 1'b0;
            write_done     <= 1'b0;
            cmd_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_rd_accept) begin
                r_rd_addr <= addr_r;
            end
            if (w_wr_accept) begin
                r_wr_addr <= addr_w;
                r_wr_data <= data_w;
            end
            // Samples the pre-edge array, so a same-edge preload is not seen.
            if (w_rd_commit) begin
                data_r <= r_mem[r_rd_addr];
            end
            read_data_done <= w_rd_commit;
            write_done     <= w_wr_commit;
            cmd_err        <= w_cmd_err_nxt;
        end
    end

    // Array has no reset. The command write comes last so it wins a
    // same-address collision with the preload port. A reset forces IDLE,
    // which drops any uncommitted write.
    always_ff @(posedge clk) begin
        if (init_we) begin
            r_mem[init_addr] <= init_data;
        end
        if (w_wr_commit) begin
            r_mem[r_wr_addr] <= r_wr_data;
        end
    end

endmodule

// File: tb/tb_image_mem_responder.sv
module tb_image_mem_responder;

    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;

    logic       clk;
    logic       n_rst;
    logic [1:0] instruction;
    logic [7:0] addr_r;
    logic [7:0] addr_w;
    logic [7:0] data_w;
    logic       init_we;
    logic [7:0] init_addr;
    logic [7:0] init_data;
    logic       busy;
    logic [7:0] data_r;
    logic       read_data_done;
    logic       write_done;
    logic       cmd_err;

    image_mem_responder #(
        .ADDR_W(8), .DATA_W(8), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
    ) u_dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .instruction    (instruction),
        .addr_r         (addr_r),
        .addr_w         (addr_w),
        .data_w         (data_w),
        .init_we        (init_we),
        .init_addr      (init_addr),
        .init_data      (init_data),
        .busy           (busy),
        .data_r         (data_r),
        .read_data_done (read_data_done),
        .write_done     (write_done),
        .cmd_err        (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         n_wr_seen = 0;
    int         n_wr_exp = 0;
    int         n_err_seen = 0;
    int         n_err_exp = 0;
    logic [7:0] mdl [256];
    logic [7:0] sb_q [$];

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Read data is checked whenever the DUT completes a read.
    always @(negedge clk) begin
        if (read_data_done) begin
            if (sb_q.size() == 0) begin
                chk_val("rd_unexpected", 32'd1, 32'd0);
            end else begin
                chk_val("rd_data", data_r, sb_q.pop_front());
            end
        end
        if (read_data_done && write_done) chk_val("both_done", 32'd1, 32'd0);
        if (write_done) n_wr_seen++;
        if (cmd_err) n_err_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_write(input logic [7:0] a, input logic [7:0] d);
        init_we = 1'b1; init_addr = a; init_data = d;
        step();
        init_we = 1'b0;
        mdl[a] = d;
    endtask

    // Issues a command, optionally drives a command while busy, and returns
    // in the done cycle so the caller may issue back-to-back.
    task automatic do_cmd(input logic [1:0] ins, input logic [7:0] ar, input logic [7:0] aw,
                          input logic [7:0] dw, input logic [1:0] busy_ins);
        int         lat;
        logic [7:0] dr0;
        dr0 = data_r;
        lat = (ins == 2'b01) ? RD_LAT : WR_LAT;
        instruction = ins; addr_r = ar; addr_w = aw; data_w = dw;
        if (ins == 2'b01) sb_q.push_back(mdl[ar]);
        step();
        instruction = busy_ins;
        addr_w = ar; data_w = 8'hFF; addr_r = 8'h00;
        for (int i = 0; i < lat; i++) begin
            chk_val("busy_mid", busy, 1'b1);
            chk_val("done_mid", {read_data_done, write_done}, 2'b00);
            step();
        end
        instruction = 2'b00;
        chk_val("busy_done", busy, 1'b0);
        if (ins == 2'b01) begin
            chk_val("rd_pulse", {read_data_done, write_done}, 2'b10);
        end else begin
            chk_val("wr_pulse", {read_data_done, write_done}, 2'b01);
            chk_val("dr_hold", data_r, dr0);
            mdl[aw] = dw;
            n_wr_exp++;
        end
    endtask

    task automatic idle_chk();
        step();
        chk_val("idle_done", {read_data_done, write_done, cmd_err}, 3'b000);
        chk_val("idle_busy", busy, 1'b0);
    endtask

    initial begin
        logic [7:0] dr_keep;
        n_rst = 1'b1; instruction = 2'b00; addr_r = '0; addr_w = '0; data_w = '0;
        init_we = 1'b0; init_addr = '0; init_data = '0;
        step(); step();
        chk_val("rst_busy", busy, 1'b0);
        chk_val("rst_data_r", data_r, 8'h00);
        chk_val("rst_pulses", {read_data_done, write_done, cmd_err}, 3'b000);
        n_rst = 1'b0;
        step();

        init_write(8'h10, 8'h5A);
        init_write(8'h20, 8'h00);
        init_write(8'h30, 8'h00);
        init_write(8'h40, 8'h00);
        init_write(8'h50, 8'hAA);

        // Basic read
        do_cmd(2'b01, 8'h10, 8'h00, 8'h00, 2'b00);
        chk_val("rd1_data_r", data_r, 8'h5A);
        idle_chk();

        // Write, data_r unchanged, then read back
        do_cmd(2'b10, 8'h00, 8'h20, 8'hC3, 2'b00);
        chk_val("wr_dr_keep", data_r, 8'h5A);
        idle_chk();
        do_cmd(2'b01, 8'h20, 8'h00, 8'h00, 2'b00);
        idle_chk();

        // Write while busy must be ignored
        do_cmd(2'b01, 8'h10, 8'h00, 8'h00, 2'b10);
        idle_chk();
        do_cmd(2'b01, 8'h10, 8'h00, 8'h00, 2'b00);
        idle_chk();

        // Reserved instruction
        dr_keep = data_r;
        instruction = 2'b11;
        step();
        instruction = 2'b00;
        n_err_exp++;
        chk_val("cmd_err_pulse", cmd_err, 1'b1);
        chk_val("cmd_err_busy", busy, 1'b0);
        chk_val("cmd_err_dones", {read_data_done, write_done}, 2'b00);
        chk_val("cmd_err_dr", data_r, dr_keep);
        idle_chk();

        // Reset in the middle of a write
        instruction = 2'b10; addr_w = 8'h30; data_w = 8'h77;
        step();
        instruction = 2'b00;
        chk_val("mid_busy", busy, 1'b1);
        n_rst = 1'b1;
        #1;
        chk_val("rst_mid_busy", busy, 1'b0);
        chk_val("rst_mid_dr", data_r, 8'h00);
        step();
        n_rst = 1'b0;
        idle_chk();
        do_cmd(2'b01, 8'h30, 8'h00, 8'h00, 2'b00);
        idle_chk();

        // Preload collides with write commit: command wins
        instruction = 2'b10; addr_w = 8'h40; data_w = 8'h22;
        step();
        instruction = 2'b00;
        init_we = 1'b1; init_addr = 8'h40; init_data = 8'h11;
        step();
        init_we = 1'b0;
        chk_val("coll_wr_pulse", write_done, 1'b1);
        mdl[8'h40] = 8'h22;
        n_wr_exp++;
        idle_chk();
        do_cmd(2'b01, 8'h40, 8'h00, 8'h00, 2'b00);
        idle_chk();

        // Preload collides with read completion: old value returned
        instruction = 2'b01; addr_r = 8'h50;
        sb_q.push_back(mdl[8'h50]);
        step();
        instruction = 2'b00;
        step();
        init_we = 1'b1; init_addr = 8'h50; init_data = 8'hBB;
        step();
        init_we = 1'b0;
        mdl[8'h50] = 8'hBB;
        chk_val("coll_rd_old", data_r, 8'hAA);
        idle_chk();
        do_cmd(2'b01, 8'h50, 8'h00, 8'h00, 2'b00);
        idle_chk();

        // Back-to-back commands issued in the done cycle
        do_cmd(2'b01, 8'h10, 8'h00, 8'h00, 2'b00);
        do_cmd(2'b01, 8'h20, 8'h00, 8'h00, 2'b00);
        do_cmd(2'b10, 8'h00, 8'h60, 8'h3C, 2'b00);
        do_cmd(2'b01, 8'h60, 8'h00, 8'h00, 2'b00);
        idle_chk();
        chk_val("b2b_data_r", data_r, 8'h3C);

        step();
        chk_val("sb_empty", sb_q.size(), 32'd0);
        chk_val("wr_count", n_wr_seen, n_wr_exp);
        chk_val("err_count", n_err_seen, n_err_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/image_mem_responder.md
Name: image_mem_responder

Overview:
- Memory-side responder for the pixel read/write command interface driven by the read/write initiator.
- Holds a DEPTH x DATA_W pixel store.
- Accepts one READ or WRITE command at a time, holds busy high for a programmable latency, then returns read data with a one-cycle read_data_done pulse, or commits write data with a one-cycle write_done pulse.
- A side-band init port lets the testbench or top level preload the source image before start.

Parameters:
- ADDR_W, 8, width of addr_r/addr_w/init_addr; DEPTH = 2**ADDR_W.
- DATA_W, 8, pixel width.
- RD_LAT, 2, cycles from read accept to read_data_done (legal 1..15).
- WR_LAT, 1, cycles from write accept to write_done (legal 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous reset, active-high (asserted when 1).
- instruction  in  2  command: 00 NOP, 01 READ, 10 WRITE, 11 reserved.
- addr_r  in  ADDR_W  read address, sampled on accept.
- addr_w  in  ADDR_W  write address, sampled on accept.
- data_w  in  DATA_W  write data, sampled on accept.
- init_we  in  1  preload write strobe.
- init_addr  in  ADDR_W  preload address.
- init_data  in  DATA_W  preload data.
- busy  out  1  command in flight; new commands ignored.
- data_r  out  DATA_W  read data, held until the next read completes.
- read_data_done  out  1  one-cycle pulse, data_r valid.
- write_done  out  1  one-cycle pulse, write committed.
- cmd_err  out  1  one-cycle pulse on reserved instruction 11.

Behaviour:
- Reset (n_rst=1, async):
  - busy=0, data_r=0, read_data_done=0, write_done=0, cmd_err=0, FSM=IDLE, latency counter=0.
  - Pixel array is not cleared.
- FSM states: IDLE, RD_WAIT, WR_WAIT.
- IDLE: at rising edge E0 with busy=0:
  - instruction=01: latch addr_r into rd_addr, cnt=RD_LAT-1, go to RD_WAIT, busy=1 after E0.
  - instruction=10: latch addr_w and data_w, cnt=WR_LAT-1, go to WR_WAIT, busy=1 after E0.
  - instruction=11: cmd_err=1 for the cycle after E0, stay IDLE, busy stays 0.
  - instruction=00: no action.
- RD_WAIT: at each edge, if cnt!=0 then cnt decrements. If cnt==0:
  - data_r <= mem[rd_addr]; read_data_done=1 for one cycle; busy=0; return to IDLE.
  - Net: done rises after edge E0+RD_LAT.
- WR_WAIT: same counting. At cnt==0:
  - mem[wr_addr] <= wr_data; write_done=1 for one cycle; busy=0; return to IDLE.
  - Net: done rises after edge E0+WR_LAT.
- Instruction, addresses and data are ignored while busy=1; only latched values are used.
- Back-to-back: in the done cycle busy=0, so a command presented in that cycle is accepted at the next edge. Peak throughput is one command per LAT+1 cycles.
- Done pulses are exactly one cycle. read_data_done and write_done are never high together.
- data_r changes only at read completion; writes never update data_r, even to the same address.
- Init port:
  - init_we=1 writes mem[init_addr] <= init_data at the edge, in any state.
  - If it coincides with a write commit to the same address, the command write wins.
  - If it coincides with a read completion to the same address, data_r returns the pre-edge (old) value.
- Reset mid-operation:
  - The in-flight command is aborted; an uncommitted write is dropped and the array is left unchanged.
  - No done pulse is emitted; data_r is forced to 0.
- Addresses wrap naturally: DEPTH = 2**ADDR_W, so there is no out-of-range case.
- Parameter values outside 1..15 are a configuration error; behaviour is unspecified.

Test Plan:
- Preload via init port mem[0x10]=0x5A. READ addr_r=0x10 at E0 → busy=1 for 2 cycles; read_data_done one cycle after edge E0+2; data_r=0x5A.
- WRITE addr_w=0x20, data_w=0xC3 → write_done after edge E0+1. Then READ 0x20 → data_r=0xC3 while data_r stays unchanged during the write.
- While busy from a READ of 0x10, drive WRITE 0x10/0xFF → ignored; no write_done. A subsequent READ 0x10 returns 0x5A.
- instruction=11 → cmd_err pulses one cycle; busy stays 0; no done pulses; data_r unchanged.
- Assert n_rst one cycle into a WRITE 0x30/0x77 → busy=0 and data_r=0 immediately; no write_done. After reset, READ 0x30 returns the preloaded 0x00.
- Simultaneous init_we to 0x40=0x11 and command write commit to 0x40=0x22 → READ 0x40 returns 0x22.
- Back-to-back: issue READ in the read_data_done cycle → accepted at the next edge with the correct latency.
